fls_seq_ctrl: RTL and testbench

//   Sequencer for one 8-bit Fibonacci-like-sequence datapath (fls: clk/rstn/en/d/f/err).

---
 rtl/fls_seq_ctrl_if.sv | 27 ++
 rtl/fls_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fls_seq_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fls_seq_ctrl_if.sv
// Board-side request/response bundle of the fls sequencer.
//   master : drives start/seed0/seed1/num_steps, observes ready/term/term_valid/done/ovf
//   slave  : the sequencer itself
interface fls_seq_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [WIDTH-1:0] seed0;
  logic [WIDTH-1:0] seed1;
  logic [CNT_W-1:0] num_steps;
  logic             ready;
  logic [WIDTH-1:0] term;
  logic             term_valid;
  logic             done;
  logic             ovf;

  modport master (
    output start, seed0, seed1, num_steps,
    input  ready, term, term_valid, done, ovf
  );

  modport slave (
    input  start, seed0, seed1, num_steps,
    output ready, term, term_valid, done, ovf
  );
endinterface

// File: rtl/fls_seq_ctrl.sv
// Sequencer for one Fibonacci-like-sequence (fls) datapath. Takes a start request
// with two seeds and a step count, clears the fls, loads both seeds, then issues
// sum steps, reporting every produced term until the count runs out or the fls
// flags overflow.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   pause           (only with FLS_CTRL_PAUSE_EN) stalls WAIT and STEP entry
//   ctl             board-side bundle (start/seeds/num_steps in; ready/term/
//                   term_valid/done/ovf out)
//   fls_rstn/en/d   control and data to the fls instance
//   fls_f/fls_err   fls current term and sticky overflow flag
// Optional feature macro: FLS_CTRL_PAUSE_EN.
module fls_seq_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FLS_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  fls_seq_ctrl_if.slave    ctl,
  output logic             fls_rstn,
  output logic             fls_en,
  output logic [WIDTH-1:0] fls_d,
  input  logic [WIDTH-1:0] fls_f,
  input  logic             fls_err
);

  localparam int unsigned WAIT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_INIT, S_LD0, S_LD1, S_CHK, S_WAIT, S_STEP, S_FIN
  } state_t;

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   seed0_q, seed0_n, seed1_q, seed1_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [WAIT_W-1:0]  wcnt_q, wcnt_n;
  logic               after_ld0_q, after_ld0_n;
  logic               ready_q, ready_n;
  logic [WIDTH-1:0]   term_q, term_n;
  logic               tv_q, tv_n;
  logic               done_q, done_n;
  logic               ovf_q, ovf_n;
  logic               fls_rstn_n, fls_en_n;
  logic [WIDTH-1:0]   fls_d_n;
  logic               stall;

`ifdef FLS_CTRL_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  assign ctl.ready      = ready_q;
  assign ctl.term       = term_q;
  assign ctl.term_valid = tv_q;
  assign ctl.done       = done_q;
  assign ctl.ovf        = ovf_q;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      seed0_q     <= '0;
      seed1_q     <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      after_ld0_q <= 1'b0;
      ready_q     <= 1'b0;
      term_q      <= '0;
      tv_q        <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      fls_rstn    <= 1'b0;
      fls_en      <= 1'b0;
      fls_d       <= '0;
    end else begin
      state_q     <= state_n;
      seed0_q     <= seed0_n;
      seed1_q     <= seed1_n;
      cnt_q       <= cnt_n;
      wcnt_q      <= wcnt_n;
      after_ld0_q <= after_ld0_n;
      ready_q     <= ready_n;
      term_q      <= term_n;
      tv_q        <= tv_n;
      done_q      <= done_n;
      ovf_q       <= ovf_n;
      fls_rstn    <= fls_rstn_n;
      fls_en      <= fls_en_n;
      fls_d       <= fls_d_n;
    end
  end

  // Next state; outputs are derived from the state being entered
  always_comb begin
    state_n     = state_q;
    seed0_n     = seed0_q;
    seed1_n     = seed1_q;
    cnt_n       = cnt_q;
    wcnt_n      = wcnt_q;
    after_ld0_n = after_ld0_q;
    term_n      = term_q;
    tv_n        = 1'b0;
    ovf_n       = ovf_q;

    case (state_q)
      S_IDLE: begin
        // ready_q gates the first cycle out of reset, when ready is still low
        if (ctl.start && ready_q) begin
          seed0_n = ctl.seed0;
          seed1_n = ctl.seed1;
          cnt_n   = ctl.num_steps;
          ovf_n   = 1'b0;
          state_n = S_CLR;
        end
      end
      S_CLR:  state_n = S_INIT;
      S_INIT: begin
        after_ld0_n = 1'b1;
        state_n     = S_LD0;
      end
      S_LD0:  state_n = S_CHK;
      S_LD1: begin
        after_ld0_n = 1'b0;
        state_n     = S_CHK;
      end
      S_STEP: begin
        cnt_n   = cnt_q - CNT_W'(1);
        state_n = S_CHK;
      end
      S_CHK: begin
        if (fls_err) begin
          ovf_n   = 1'b1;
          state_n = S_FIN;
        end else begin
          term_n = fls_f;
          tv_n   = 1'b1;
          if (after_ld0_q) begin
            state_n = S_LD1;
          end else if (cnt_q == '0) begin
            state_n = S_FIN;
          end else if (STEP_DIV == 1 && !stall) begin
            state_n = S_STEP;
          end else begin
            // With STEP_DIV=1 this path is only taken under pause; a zero
            // preload lets WAIT release straight into STEP once pause drops.
            wcnt_n  = WAIT_W'(STEP_DIV - 1);
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!stall) begin
          if (wcnt_q <= WAIT_W'(1)) state_n = S_STEP;
          else                      wcnt_n  = wcnt_q - WAIT_W'(1);
        end
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    ready_n    = (state_n == S_IDLE);
    done_n     = (state_n == S_FIN);
    fls_rstn_n = (state_n != S_CLR);
    fls_en_n   = (state_n == S_LD0) || (state_n == S_LD1) || (state_n == S_STEP);
    fls_d_n    = (state_n == S_LD0) ? seed0_q :
                 (state_n == S_LD1) ? seed1_q : '0;
  end

endmodule

// File: tb/tb_fls_seq_ctrl.sv
// Bench for fls_seq_ctrl: a behavioural fls stand-in, a term/pulse monitor and a
// reference model that computes expected terms from the seeds with plain integers.
module tb_fls_seq_ctrl;
  localparam int unsigned STEP_DIV = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fls_rstn, fls_en, fls_err;
  logic [7:0] fls_d, fls_f;
`ifdef FLS_CTRL_PAUSE_EN
  logic       pause = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int got_q[$];
  int en_q[$];

  fls_seq_ctrl_if #(.WIDTH(8), .CNT_W(8)) bus ();

  fls_seq_ctrl #(.WIDTH(8), .CNT_W(8), .STEP_DIV(STEP_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef FLS_CTRL_PAUSE_EN
    .pause    (pause),
`endif
    .ctl      (bus),
    .fls_rstn (fls_rstn),
    .fls_en   (fls_en),
    .fls_d    (fls_d),
    .fls_f    (fls_f),
    .fls_err  (fls_err)
  );

  always #5 clk = ~clk;

  // fls stand-in: two loads shift seeds in, then each enable adds the last two terms
  logic [7:0] fa = '0, fb = '0;
  logic [1:0] fn = '0;
  logic       ferr = 1'b0;
  logic [8:0] fsum;
  assign fsum    = {1'b0, fa} + {1'b0, fb};
  assign fls_f   = fb;
  assign fls_err = ferr;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!fls_rstn) begin
      fa <= '0; fb <= '0; fn <= '0; ferr <= 1'b0;
    end else if (fls_en) begin
      fa <= fb;
      if (fn < 2) begin
        fb <= fls_d;
        fn <= fn + 2'd1;
      end else begin
        fb <= fsum[7:0];
        if (fsum[8]) ferr <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.term_valid === 1'b1) got_q.push_back(int'(bus.term));
    if (bus.done === 1'b1) done_cnt++;
    if (fls_en === 1'b1) en_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One full run; poke pulses a foreign start mid-run, pz>0 pauses there for 10 cycles
  task automatic run(input int s0, input int s1, input int n, input bit poke, input int pz);
    int exp_q[$];
    int steps_exec, sum, base_done, budget, limit, en_at_pause;
    bit exp_ovf;
    exp_q = {s0, s1};
    steps_exec = 0;
    exp_ovf = 1'b0;
    for (int k = 0; k < n; k++) begin
      steps_exec++;
      sum = exp_q[exp_q.size()-2] + exp_q[exp_q.size()-1];
      if (sum > 255) begin
        exp_ovf = 1'b1;
        break;
      end
      exp_q.push_back(sum);
    end

    budget = 0;
    while (bus.ready !== 1'b1 && budget < 50) begin tick(); budget++; end
    chk("ready_before_start", 32'(bus.ready), 1);

    got_q.delete();
    en_q.delete();
    base_done = done_cnt;
    en_at_pause = 0;
    bus.seed0 = 8'(s0);
    bus.seed1 = 8'(s1);
    bus.num_steps = 8'(n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ready_low_after_accept", 32'(bus.ready), 0);

    budget = 0;
    limit = (n + 3) * (int'(STEP_DIV) + 2) + 60;
    while (done_cnt == base_done && budget < limit) begin
      bus.start = 1'b0;
      if (poke && budget == 8) begin
        bus.start = 1'b1;
        bus.seed0 = 8'd200;
        bus.seed1 = 8'd200;
        bus.num_steps = 8'd1;
      end
`ifdef FLS_CTRL_PAUSE_EN
      if (pz > 0 && budget == pz) begin
        pause = 1'b1;
        en_at_pause = en_q.size();
      end
      if (pz > 0 && budget == pz + 10) begin
        chk("no_en_during_pause", 32'(en_q.size()), 32'(en_at_pause));
        pause = 1'b0;
      end
`else
      en_at_pause = pz;
`endif
      tick();
      budget++;
    end
    bus.start = 1'b0;
    chk("done_pulse", 32'(done_cnt - base_done), 1);
    tick();
    chk("done_single_cycle", 32'(done_cnt - base_done), 1);
    chk("ready_after_done", 32'(bus.ready), 1);
    chk("ovf", 32'(bus.ovf), 32'(exp_ovf));
    chk("term_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("term[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
    chk("term_hold", 32'(bus.term), 32'(exp_q[exp_q.size()-1]));
    chk("en_pulses", 32'(en_q.size()), 32'(2 + steps_exec));
    if (en_q.size() >= 2) chk("load_spacing", 32'(en_q[1] - en_q[0]), 2);
    if (pz == 0)
      for (int i = 2; i < en_q.size(); i++)
        chk($sformatf("step_spacing[%0d]", i), 32'(en_q[i] - en_q[i-1]), 32'(STEP_DIV + 1));
  endtask

  initial begin
    int budget, base_done;
    bus.start = 1'b0;
    bus.seed0 = '0;
    bus.seed1 = '0;
    bus.num_steps = '0;

    tick();
    tick();
    chk("rst_ready", 32'(bus.ready), 0);
    chk("rst_term", 32'(bus.term), 0);
    chk("rst_term_valid", 32'(bus.term_valid), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    chk("rst_fls_rstn", 32'(fls_rstn), 0);
    chk("rst_fls_en", 32'(fls_en), 0);
    chk("rst_fls_d", 32'(fls_d), 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(bus.ready), 1);
    chk("fls_rstn_idle", 32'(fls_rstn), 1);

    run(1, 1, 5, 1'b0, 0);
    run(89, 144, 3, 1'b0, 0);
    run(7, 9, 0, 1'b0, 0);
    run(2, 3, 3, 1'b0, 0);
    run(0, 0, 255, 1'b0, 0);
    run(0, 1, 13, 1'b0, 0);
    run(1, 2, 4, 1'b1, 0);
    for (int r = 0; r < 6; r++)
      run(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 12)), 1'b0, 0);
    for (int r = 0; r < 3; r++)
      run(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
          int'($urandom_range(1, 10)), 1'b0, 0);

    // reset in the middle of a run
    got_q.delete();
    base_done = done_cnt;
    bus.seed0 = 8'd3;
    bus.seed1 = 8'd4;
    bus.num_steps = 8'd6;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    budget = 0;
    while (got_q.size() < 2 && budget < 40) begin tick(); budget++; end
    chk("midrst_two_terms", 32'(got_q.size()), 2);
    rst = 1'b1;
    #1;
    chk("midrst_fls_rstn", 32'(fls_rstn), 0);
    chk("midrst_ready", 32'(bus.ready), 0);
    chk("midrst_fls_en", 32'(fls_en), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_ready_after", 32'(bus.ready), 1);
    tick();
    chk("midrst_no_done", 32'(done_cnt - base_done), 0);

    run(5, 8, 4, 1'b0, 0);
`ifdef FLS_CTRL_PAUSE_EN
    run(1, 1, 8, 1'b0, 14);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
